// File: rtl/life_sequencer.sv
// ----------------------------------------------------------------------------
// life_sequencer
// Run controller for the 8x8 Game-of-Life grid datapath. It loads the grid
// from an external seed or an internal 64-bit Galois LFSR, then issues paced
// single-generation step strobes. After each step it checks the new grid for
// extinction, for a still life, and for the generation limit, and halts when
// one of them occurs.
//
// Ports
//   i_clk        system clock, rising edge
//   i_reset      synchronous, active-low reset
//   i_start      begin / resume stepping (level)
//   i_stop       pause stepping
//   i_randomize  load grid from LFSR
//   i_seed_load  load grid from i_muxseed
//   i_muxseed    external seed pattern
//   i_max_gen    generation limit, 0 = unlimited
//   i_grid_in    current grid from the datapath
//   o_load_en    datapath load strobe
//   o_load_data  pattern to load (held after the load)
//   o_step_en    one-generation advance strobe
//   o_gen_count  generations since the last load (saturating)
//   o_busy       high in RUN / STEP / CHECK
//   o_done       high in DONE
//   o_status     00 none, 01 extinct, 10 stable, 11 limit
//
// state | meaning
// IDLE  | waiting for a load or start request
// LOAD  | load_en high for one cycle, counters cleared
// RUN   | pacing down-counter between steps
// STEP  | step_en high, pre-step grid captured
// CHECK | new generation on grid_in, termination checks
// DONE  | halted, status held until the next load
// ----------------------------------------------------------------------------
module life_sequencer #(
   parameter int                WIDTH     = 64,
   parameter int                GEN_W     = 16,
   parameter int                STEP_DIV  = 4,
   parameter logic [63:0]       LFSR_INIT = 64'hACE1_0000_0000_0001
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic                 i_randomize,
   input  logic                 i_seed_load,
   input  logic [WIDTH-1:0]     i_muxseed,
   input  logic [GEN_W-1:0]     i_max_gen,
   input  logic [WIDTH-1:0]     i_grid_in,
   output logic                 o_load_en,
   output logic [WIDTH-1:0]     o_load_data,
   output logic                 o_step_en,
   output logic [GEN_W-1:0]     o_gen_count,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [1:0]           o_status
);

   localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(STEP_DIV - 1);
   // Right-shift Galois mask for x^64 + x^63 + x^61 + x^60 + 1.
   localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_RUN, S_STEP, S_CHECK, S_DONE
   } state_t;

   state_t             r_state;
   logic [63:0]        r_lfsr;
   logic [DIV_W-1:0]   r_div;
   logic [WIDTH-1:0]   r_prev;
   logic               r_load_en;
   logic [WIDTH-1:0]   r_load_data;
   logic               r_step_en;
   logic [GEN_W-1:0]   r_gen_count;
   logic               r_busy;
   logic               r_done;
   logic [1:0]         r_status;

   logic [63:0]        w_lfsr_nxt;
   logic               w_load_req;
   logic [WIDTH-1:0]   w_load_pat;
   logic [GEN_W-1:0]   w_gen_inc;
   logic               w_limit_hit;

   assign w_lfsr_nxt  = {1'b0, r_lfsr[63:1]} ^ ({64{r_lfsr[0]}} & LFSR_TAPS);
   assign w_load_req  = i_randomize | i_seed_load;
   // randomize outranks seed_load when both are requested.
   assign w_load_pat  = i_randomize ? r_lfsr[WIDTH-1:0] : i_muxseed;
   assign w_gen_inc   = (r_gen_count == '1) ? r_gen_count : r_gen_count + GEN_W'(1);
   assign w_limit_hit = (i_max_gen != '0) && (w_gen_inc >= i_max_gen);

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_lfsr      <= LFSR_INIT;
         r_div       <= '0;
         r_prev      <= '0;
         r_load_en   <= 1'b0;
         r_load_data <= '0;
         r_step_en   <= 1'b0;
         r_gen_count <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_status    <= 2'b00;
      end else begin
         r_lfsr    <= w_lfsr_nxt;
         r_load_en <= 1'b0;
         r_step_en <= 1'b0;

         // Any state that honours a load request enters LOAD the same way.
         if ((r_state == S_IDLE || r_state == S_RUN || r_state == S_DONE) && w_load_req) begin
            r_state     <= S_LOAD;
            r_load_en   <= 1'b1;
            r_load_data <= w_load_pat;
            r_gen_count <= '0;
            r_status    <= 2'b00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  // stop outranks start, so both together keep us idle.
                  if (!i_stop && i_start) begin
                     r_state <= S_RUN;
                     r_div   <= DIV_LOAD;
                     r_busy  <= 1'b1;
                  end
               end
               S_LOAD: begin
                  r_gen_count <= '0;
                  r_status    <= 2'b00;
                  r_state     <= S_IDLE;
               end
               S_RUN: begin
                  if (i_stop) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else if (r_div == '0) begin
                     r_state   <= S_STEP;
                     r_step_en <= 1'b1;
                  end else begin
                     r_div <= r_div - DIV_W'(1);
                  end
               end
               S_STEP: begin
                  r_prev  <= i_grid_in;
                  r_state <= S_CHECK;
               end
               S_CHECK: begin
                  r_gen_count <= w_gen_inc;
                  if (i_grid_in == '0) begin
                     r_state  <= S_DONE;
                     r_status <= 2'b01;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                  end else if (i_grid_in == r_prev) begin
                     r_state  <= S_DONE;
                     r_status <= 2'b10;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                  end else if (w_limit_hit) begin
                     r_state  <= S_DONE;
                     r_status <= 2'b11;
                     r_busy   <= 1'b0;
                     r_done   <= 1'b1;
                  end else if (i_stop) begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= S_RUN;
                     r_div   <= DIV_LOAD;
                  end
               end
               S_DONE: begin
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_load_en   = r_load_en;
   assign o_load_data = r_load_data;
   assign o_step_en   = r_step_en;
   assign o_gen_count = r_gen_count;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_status    = r_status;

endmodule

// File: tb/tb_life_sequencer.sv
// ----------------------------------------------------------------------------
// tb_life_sequencer
// Directed stimulus pushes expected events (load, step, done) into a queue;
// a monitor on the falling edge pops and compares whenever the DUT presents
// one. A small Game-of-Life datapath model drives grid_in.
// ----------------------------------------------------------------------------
module tb_life_sequencer;

   localparam int          STEP_DIV  = 4;
   localparam logic [63:0] LFSR_INIT = 64'hACE1_0000_0000_0001;
   localparam logic [63:0] TAPS      = 64'hD800_0000_0000_0000;

   localparam int K_LOAD = 0;
   localparam int K_STEP = 1;
   localparam int K_DONE = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        randomize = 1'b0;
   logic        seed_load = 1'b0;
   logic [63:0] muxseed = '0;
   logic [15:0] max_gen = '0;
   logic [63:0] grid;
   logic        load_en;
   logic [63:0] load_data;
   logic        step_en;
   logic [15:0] gen_count;
   logic        busy;
   logic        done;
   logic [1:0]  status;

   life_sequencer #(
      .WIDTH(64), .GEN_W(16), .STEP_DIV(STEP_DIV), .LFSR_INIT(LFSR_INIT)
   ) dut (
      .i_clk(clk), .i_reset(reset), .i_start(start), .i_stop(stop),
      .i_randomize(randomize), .i_seed_load(seed_load), .i_muxseed(muxseed),
      .i_max_gen(max_gen), .i_grid_in(grid),
      .o_load_en(load_en), .o_load_data(load_data), .o_step_en(step_en),
      .o_gen_count(gen_count), .o_busy(busy), .o_done(done), .o_status(status)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [63:0] data;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;
   int   cyc = 0;
   logic done_q = 1'b0;
   logic [63:0] m_lfsr;

   function automatic logic [63:0] life_next(input logic [63:0] g);
      logic [63:0] n;
      int cnt;
      int rr;
      int cc;
      n = '0;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  rr = r + dr;
                  cc = c + dc;
                  if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 8 && cc >= 0 && cc < 8)
                     if (g[rr*8+cc]) cnt++;
               end
            end
            n[r*8+c] = g[r*8+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
         end
      end
      return n;
   endfunction

   // Datapath and LFSR reference models.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset) begin
         grid   <= '0;
         m_lfsr <= LFSR_INIT;
      end else begin
         m_lfsr <= {1'b0, m_lfsr[63:1]} ^ (m_lfsr[0] ? TAPS : 64'h0);
         if (load_en)      grid <= load_data;
         else if (step_en) grid <= life_next(grid);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic pop_check(input int kind, output exp_t e, output bit ok);
      ok = 1'b0;
      if (q.size() == 0) begin
         check($sformatf("unexpected_event_kind%0d", kind), 64'(1), 64'(0));
      end else begin
         e = q.pop_front();
         ok = (e.kind == kind);
         if (!ok) check("event_kind", 64'(kind), 64'(e.kind));
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit   ok;
      if (reset) begin
         if (load_en) begin
            pop_check(K_LOAD, e, ok);
            if (ok) check("load_data", load_data, e.data);
         end
         if (step_en) begin
            pop_check(K_STEP, e, ok);
            if (ok) begin
               check("step_cycle", 64'(cyc), 64'(e.cyc));
               check("step_gen", 64'(gen_count), e.data);
            end
         end
         if (done && !done_q) begin
            pop_check(K_DONE, e, ok);
            if (ok) check("done_status_gen", {46'd0, status, gen_count}, e.data);
         end
      end
      done_q <= done;
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(input int kind, input logic [63:0] data, input int c);
      exp_t e;
      e.kind = kind;
      e.data = data;
      e.cyc  = c;
      q.push_back(e);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (q.size() != 0 && n < 300) begin
         tick();
         n++;
      end
      if (q.size() != 0) begin
         check("drain_timeout", 64'(q.size()), 64'(0));
         q.delete();
      end
   endtask

   // Seed load from the current state; returns in IDLE after LOAD.
   task automatic do_seed(input logic [63:0] pat);
      seed_load = 1'b1;
      muxseed   = pat;
      push(K_LOAD, pat, 0);
      tick();
      seed_load = 1'b0;
      wait_drain();
      tick();
   endtask

   // Start pulse from IDLE; returns the edge that accepts it.
   task automatic start_pulse(output int t);
      start = 1'b1;
      t = cyc + 1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int   t;
      int   steps;
      logic [63:0] lf;

      // Reset held with start asserted.
      start = 1'b1;
      tick();
      tick();
      check("reset_outputs", {load_en, step_en, busy, done, status, gen_count, load_data},
            '0);
      reset = 1'b1;
      t = cyc + 1;
      push(K_STEP, 64'd0, t + STEP_DIV);
      push(K_DONE, {46'd0, 2'b01, 16'd1}, 0);
      wait_drain();
      start = 1'b0;

      // Extinction: single cell dies.
      do_seed(64'h0000_0000_0000_0001);
      check("load_clears", {46'd0, status, gen_count, 1'b0, done}, '0);
      start_pulse(t);
      push(K_STEP, 64'd0, t + STEP_DIV);
      push(K_DONE, {46'd0, 2'b01, 16'd1}, 0);
      wait_drain();

      // Still life: 2x2 block.
      do_seed(64'h0000_0018_1800_0000);
      start_pulse(t);
      push(K_STEP, 64'd0, t + STEP_DIV);
      push(K_DONE, {46'd0, 2'b10, 16'd1}, 0);
      wait_drain();

      // Generation limit on a blinker, start held.
      max_gen = 16'd5;
      do_seed(64'h0000_0000_001C_0000);
      start = 1'b1;
      t = cyc + 1;
      for (int k = 0; k < 5; k++) push(K_STEP, 64'(k), t + STEP_DIV + 6 * k);
      push(K_DONE, {46'd0, 2'b11, 16'd5}, 0);
      wait_drain();
      tick();
      tick();
      start = 1'b0;
      check("done_ignores_start", {62'd0, done, busy}, 64'b10);

      // Pause and resume.
      max_gen = 16'd0;
      do_seed(64'h0000_0000_001C_0000);
      start_pulse(t);
      push(K_STEP, 64'd0, t + STEP_DIV);
      push(K_STEP, 64'd1, t + STEP_DIV + 6);
      wait_drain();
      tick();
      tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check("pause_busy", 64'(busy), 64'd0);
      check("pause_gen", 64'(gen_count), 64'd2);
      steps = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (step_en) steps++;
      end
      check("pause_no_steps", 64'(steps), 64'd0);
      check("pause_gen_frozen", 64'(gen_count), 64'd2);
      start_pulse(t);
      push(K_STEP, 64'd2, t + STEP_DIV);
      wait_drain();

      // Randomize while running aborts to LOAD.
      tick();
      tick();
      check("run_busy", 64'(busy), 64'd1);
      lf = m_lfsr;
      randomize = 1'b1;
      push(K_LOAD, lf, 0);
      tick();
      randomize = 1'b0;
      wait_drain();
      check("abort_gen", 64'(gen_count), 64'd0);
      tick();

      // Simultaneous requests in IDLE.
      lf = m_lfsr;
      randomize = 1'b1;
      seed_load = 1'b1;
      muxseed   = 64'h1234_5678_9ABC_DEF0;
      push(K_LOAD, lf, 0);
      tick();
      randomize = 1'b0;
      seed_load = 1'b0;
      wait_drain();
      tick();
      start = 1'b1;
      stop  = 1'b1;
      tick();
      tick();
      tick();
      check("start_stop_idle", 64'(busy), 64'd0);
      start = 1'b0;
      stop  = 1'b0;

      // Reset during a step strobe.
      start_pulse(t);
      push(K_STEP, 64'd0, t + STEP_DIV);
      wait_drain();
      reset = 1'b0;
      tick();
      check("reset_mid_step", {61'd0, step_en, busy, load_en}, '0);
      check("reset_mid_gen", 64'(gen_count), 64'd0);
      reset = 1'b1;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/life_sequencer.md
Name: life_sequencer

Overview:
- Run controller for the 8x8 Game-of-Life grid datapath.
- Loads the grid from either an external 64-bit seed or an internal 64-bit LFSR, then issues paced single-generation step pulses.
- After every step it checks the new grid for extinction, for a still life, and for a generation limit, and halts when any of them occurs.
- Sits between the user/top-level controls (start, stop, randomize, seed load) and the grid update datapath.

Parameters:
- WIDTH, 64, grid bits (8x8, row r = bits [8r+7:8r]).
- GEN_W, 16, generation counter width.
- STEP_DIV, 4, RUN cycles between steps (must be >= 1).
- LFSR_INIT, 64'hACE1_0000_0000_0001, LFSR reset value (must be nonzero).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low.
- start  input  1  begin or resume stepping (level, sampled each cycle).
- stop  input  1  pause stepping.
- randomize  input  1  load grid from LFSR.
- seed_load  input  1  load grid from muxseed.
- muxseed  input  WIDTH  external seed pattern.
- max_gen  input  GEN_W  generation limit; 0 = unlimited.
- grid_in  input  WIDTH  current grid from datapath.
- load_en  output  1  datapath load strobe.
- load_data  output  WIDTH  pattern to load.
- step_en  output  1  one-generation advance strobe.
- gen_count  output  GEN_W  generations since last load.
- busy  output  1  high in RUN/STEP/CHECK.
- done  output  1  high in DONE.
- status  output  2  00 none, 01 extinct, 10 stable, 11 limit.

Behaviour:
- Reset (reset==0 at clk edge):
  - State IDLE.
  - load_en=0, load_data=0, step_en=0, gen_count=0, busy=0, done=0, status=00.
  - LFSR = LFSR_INIT.
- LFSR:
  - Galois, polynomial x^64+x^63+x^61+x^60+1.
  - Advances every non-reset cycle.
- Datapath contract: the datapath loads load_data on the edge after load_en, and presents the new generation on grid_in one cycle after step_en.
- Request priority in every state: randomize > seed_load > stop > start.
- IDLE:
  - randomize -> LOAD, with load_data <= current LFSR value.
  - seed_load -> LOAD, with load_data <= muxseed.
  - start (no load request) -> RUN, with div counter <= STEP_DIV-1.
  - Otherwise stay in IDLE.
- LOAD:
  - load_en=1 for exactly one cycle.
  - gen_count <= 0, status <= 00.
  - Next state IDLE. start must be re-asserted or held to run.
- RUN:
  - randomize or seed_load -> LOAD (abort).
  - stop -> IDLE (pause; gen_count and status kept).
  - div counter == 0 -> STEP; otherwise decrement the counter.
- STEP:
  - step_en=1 for one cycle.
  - prev <= grid_in (pre-step grid).
  - Next state CHECK. Requests are not acted on here.
- CHECK (grid_in holds the new generation):
  - gen_count <= gen_count+1, saturating at all-ones.
  - Checks in order:
    - grid_in==0 -> DONE, status 01.
    - grid_in==prev -> DONE, status 10.
    - max_gen!=0 and gen_count+1 >= max_gen -> DONE, status 11.
  - If no check fires: stop pending -> IDLE; else back to RUN, with counter reloaded.
  - A load request pending in CHECK is taken in the next state (IDLE or RUN or DONE) on the following cycle.
- DONE:
  - done=1 and status held.
  - start and stop are ignored.
  - randomize or seed_load -> LOAD (clears done and status).
- Timing:
  - Generation period = STEP_DIV+2 cycles.
  - start accepted at edge t -> step_en high in cycle t+STEP_DIV+1.
- Outputs:
  - All outputs are registered.
  - busy = (state in RUN, STEP, CHECK).
  - load_data holds its value after LOAD.
- Reset mid-operation: returns to IDLE within the same edge. Any in-flight step_en or load_en drops in that cycle.

Test Plan:
- Reset: assert reset=0 for 2 cycles with start=1 -> all outputs 0, no step_en, state IDLE; after release with start held, first step_en appears STEP_DIV+1 cycles later.
- Extinction: seed_load with muxseed=64'h0000_0000_0000_0001, then start -> one step_en; done=1, status=01, gen_count=1.
- Still life: seed 64'h0000_0018_1800_0000 (2x2 block), then start -> done=1, status=10, gen_count=1.
- Limit: seed a blinker 64'h0000_0000_001C_0000 with max_gen=5, start held -> exactly 5 step_en pulses spaced STEP_DIV+2=6 cycles apart; done=1, status=11, gen_count=5.
- Pause/abort:
  - With the blinker running, pulse stop -> busy drops, gen_count is frozen, and no step_en occurs for 20 cycles.
  - Re-assert start -> stepping resumes from the frozen gen_count.
  - Assert randomize while in RUN -> load_en pulses once, load_data equals the bench LFSR model value, gen_count=0.
- Simultaneous requests: randomize=1 and seed_load=1 in IDLE -> load_data equals the LFSR value, not muxseed. start=1 with stop=1 in IDLE -> no transition to RUN.
